// File: rtl/yapp_pkt_tx.sv
// YAPP packet transmitter: buffers up to 63 payload bytes and frames header/payload/parity to the router.
// Optional YAPP_TX_PARITY_ERR_EN adds inject_perr to invert the parity byte of one packet.
module yapp_pkt_tx #(
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             send,
    input  logic [5:0]       send_len,
    input  logic [1:0]       send_addr,
`ifdef YAPP_TX_PARITY_ERR_EN
    input  logic             inject_perr,
`endif
    output logic             busy,
    output logic [5:0]       wr_count,
    output logic             err_len,
    output logic [7:0]       in_data,
    output logic             in_data_vld,
    input  logic             in_suspend,
    output logic [CNT_W-1:0] pkt_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HEADER  = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] PARITY  = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [7:0]       buf_q [0:62];
    logic [7:0]       buf_d [0:62];
    logic [5:0]       wr_count_q, wr_count_d;
    logic             busy_q, busy_d;
    logic             err_len_q, err_len_d;
    logic [7:0]       in_data_q, in_data_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic [5:0]       len_q, len_d;
    logic [5:0]       idx_q, idx_d;
    logic [7:0]       par_q, par_d;
    logic [3:0]       gap_q, gap_d;
    logic             perr_q, perr_d;
    logic             xfer, accept;

    always_comb begin
        xfer        = vld_q & ~in_suspend;
        accept      = (state_q == IDLE) && send && (send_len != 6'd0) && (send_len <= wr_count_q);
        state_d     = state_q;
        buf_d       = buf_q;
        wr_count_d  = wr_count_q;
        busy_d      = busy_q;
        err_len_d   = (state_q == IDLE) && send && !accept;
        in_data_d   = in_data_q;
        vld_d       = vld_q;
        pkt_count_d = pkt_count_q;
        len_d       = len_q;
        idx_d       = idx_q;
        par_d       = par_q;
        gap_d       = gap_q;
        perr_d      = perr_q;

        // Buffer only fills while idle; a write coinciding with an accepted send is dropped.
        if ((state_q == IDLE) && wr_en && !accept && (wr_count_q != 6'd63)) begin
            buf_d[wr_count_q] = wr_data;
            wr_count_d        = wr_count_q + 6'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = HEADER;
                    busy_d    = 1'b1;
                    vld_d     = 1'b1;
                    in_data_d = {send_len, send_addr};
                    par_d     = {send_len, send_addr};
                    len_d     = send_len;
`ifdef YAPP_TX_PARITY_ERR_EN
                    perr_d    = inject_perr;
`else
                    perr_d    = 1'b0;
`endif
                end
            end
            HEADER: begin
                if (xfer) begin
                    state_d   = PAYLOAD;
                    idx_d     = 6'd0;
                    in_data_d = buf_q[0];
                    par_d     = par_q ^ buf_q[0];
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    if (idx_q == len_q - 6'd1) begin
                        state_d   = PARITY;
                        in_data_d = perr_q ? ~par_q : par_q;
                    end else begin
                        idx_d     = idx_q + 6'd1;
                        in_data_d = buf_q[idx_q + 6'd1];
                        par_d     = par_q ^ buf_q[idx_q + 6'd1];
                    end
                end
            end
            PARITY: begin
                if (xfer) begin
                    vld_d       = 1'b0;
                    in_data_d   = 8'h00;
                    pkt_count_d = pkt_count_q + 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        wr_count_d = 6'd0;
                    end else begin
                        state_d = GAP;
                        gap_d   = 4'd0;
                    end
                end
            end
            GAP: begin
                if (gap_q == 4'(GAP_CYCLES - 1)) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    wr_count_d = 6'd0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < 63; i++) buf_q[i] <= 8'h00;
            wr_count_q  <= 6'd0;
            busy_q      <= 1'b0;
            err_len_q   <= 1'b0;
            in_data_q   <= 8'h00;
            vld_q       <= 1'b0;
            pkt_count_q <= '0;
            len_q       <= 6'd0;
            idx_q       <= 6'd0;
            par_q       <= 8'h00;
            gap_q       <= 4'd0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            wr_count_q  <= wr_count_d;
            busy_q      <= busy_d;
            err_len_q   <= err_len_d;
            in_data_q   <= in_data_d;
            vld_q       <= vld_d;
            pkt_count_q <= pkt_count_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            par_q       <= par_d;
            gap_q       <= gap_d;
            perr_q      <= perr_d;
        end
    end

    assign busy        = busy_q;
    assign wr_count    = wr_count_q;
    assign err_len     = err_len_q;
    assign in_data     = in_data_q;
    assign in_data_vld = vld_q;
    assign pkt_count   = pkt_count_q;

endmodule
